// File: rtl/prio_pkg.sv
// Shared constants and helpers for the priority encoder slice.
package prio_pkg;

    localparam int PRIO_WIDTH_DEF = 4;

    // Index width for an n-input encoder; never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage : prio_pkg

// File: rtl/priority_encoder_core.sv
// Combinational priority encoder: the highest set bit of r wins.
module priority_encoder_core
    import prio_pkg::*;
#(
    parameter int WIDTH = PRIO_WIDTH_DEF,
    localparam int IDX_W = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] r,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic [WIDTH-1:0] oh
);

    // Scanning upward lets each later (higher) set bit overwrite earlier ones.
    always_comb begin
        idx = '0;
        any = 1'b0;
        oh  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r[i]) begin
                idx   = IDX_W'(i);
                any   = 1'b1;
                oh    = '0;
                oh[i] = 1'b1;
            end
        end
    end

endmodule : priority_encoder_core

// File: rtl/priority_encoder_sync.sv
// Registered priority encoder with per-bit request mask and capture enable.
module priority_encoder_sync
    import prio_pkg::*;
#(
    parameter int WIDTH = PRIO_WIDTH_DEF,
    localparam int IDX_W = clog2_min1(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] mask,
    output logic [IDX_W-1:0] out,
    output logic             valid,
    output logic [WIDTH-1:0] onehot
);

    logic [WIDTH-1:0] r;
    logic [IDX_W-1:0] idx_next;
    logic             any_next;
    logic [WIDTH-1:0] oh_next;

    assign r = d & mask;

    priority_encoder_core #(.WIDTH(WIDTH)) u_core (
        .r   (r),
        .idx (idx_next),
        .any (any_next),
        .oh  (oh_next)
    );

    // Outputs are registered only, so downstream sees no combinational path from d/mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out    <= '0;
            valid  <= 1'b0;
            onehot <= '0;
        end else if (en) begin
            out    <= idx_next;
            valid  <= any_next;
            onehot <= oh_next;
        end
    end

endmodule : priority_encoder_sync

// File: tb/tb_priority_encoder_sync.sv
// Directed bench for priority_encoder_sync at WIDTH=4 and WIDTH=5.
module tb_priority_encoder_sync;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] d;
    logic [3:0] mask;
    logic [1:0] out;
    logic       valid;
    logic [3:0] onehot;

    logic       en5;
    logic [4:0] d5;
    logic [4:0] mask5;
    logic [2:0] out5;
    logic       valid5;
    logic [4:0] onehot5;

    int checks = 0;
    int errors = 0;

    // Hand-derived winning index for every 4-bit request value.
    logic [1:0] exp_out_tab [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                     2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};

    priority_encoder_sync #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .d      (d),
        .mask   (mask),
        .out    (out),
        .valid  (valid),
        .onehot (onehot)
    );

    priority_encoder_sync #(.WIDTH(5)) dut5 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en5),
        .d      (d5),
        .mask   (mask5),
        .out    (out5),
        .valid  (valid5),
        .onehot (onehot5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check4(input string tag, input logic [1:0] e_out, input logic e_valid,
                          input logic [3:0] e_oh);
        check({tag, ".out"}, 32'(out), 32'(e_out));
        check({tag, ".valid"}, 32'(valid), 32'(e_valid));
        check({tag, ".onehot"}, 32'(onehot), 32'(e_oh));
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        d     = 4'b1000;
        mask  = 4'hF;
        en5   = 1'b0;
        d5    = '0;
        mask5 = 5'h1F;

        // Reset held: outputs stay cleared despite a pending request.
        for (int c = 0; c < 3; c++) begin
            step();
            check4("reset_hold", 2'd0, 1'b0, 4'b0000);
        end
        check("reset_hold.out5", 32'(out5), 32'd0);
        rst_n = 1'b1;
        step();
        check4("reset_release", 2'd3, 1'b1, 4'b1000);

        // Exhaustive sweep with mask all-ones.
        for (int v = 0; v < 16; v++) begin
            d = 4'(v);
            step();
            check4($sformatf("sweep_d%0d", v), exp_out_tab[v], (v != 0),
                   (v != 0) ? (4'b0001 << exp_out_tab[v]) : 4'b0000);
        end

        // Mask gating.
        d    = 4'b1010;
        mask = 4'b0111;
        step();
        check4("mask_0111", 2'd1, 1'b1, 4'b0010);
        mask = 4'b0000;
        step();
        check4("mask_0000", 2'd0, 1'b0, 4'b0000);
        mask = 4'b1100;
        d    = 4'b0111;
        step();
        check4("mask_1100", 2'd2, 1'b1, 4'b0100);
        mask = 4'hF;

        // Enable hold.
        d = 4'b0100;
        step();
        check4("en_capture", 2'd2, 1'b1, 4'b0100);
        en = 1'b0;
        d  = 4'b1000;
        for (int c = 0; c < 4; c++) begin
            step();
            check4("en_hold", 2'd2, 1'b1, 4'b0100);
        end
        d = 4'b0000;
        step();
        check4("en_hold_zero", 2'd2, 1'b1, 4'b0100);
        d  = 4'b1000;
        en = 1'b1;
        step();
        check4("en_raise", 2'd3, 1'b1, 4'b1000);

        // Asynchronous reset between edges clears before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        check4("async_reset", 2'd0, 1'b0, 4'b0000);
        step();
        check4("async_reset_held", 2'd0, 1'b0, 4'b0000);
        rst_n = 1'b1;
        step();
        check4("async_reset_release", 2'd3, 1'b1, 4'b1000);

        // WIDTH=5 instance.
        en5 = 1'b1;
        d5  = 5'b10000;
        step();
        check("w5_10000.out", 32'(out5), 32'd4);
        check("w5_10000.onehot", 32'(onehot5), 32'b10000);
        d5 = 5'b00011;
        step();
        check("w5_00011.out", 32'(out5), 32'd1);
        check("w5_00011.valid", 32'(valid5), 32'd1);
        d5 = 5'b11111;
        step();
        check("w5_11111.out", 32'(out5), 32'd4);
        d5 = 5'b01001;
        step();
        check("w5_01001.out", 32'(out5), 32'd3);
        check("w5_01001.onehot", 32'(onehot5), 32'b01000);
        d5    = 5'b10100;
        mask5 = 5'b01111;
        step();
        check("w5_masked.out", 32'(out5), 32'd2);
        d5 = 5'b10000;
        step();
        check("w5_masked_none.valid", 32'(valid5), 32'd0);
        check("w5_masked_none.out", 32'(out5), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_priority_encoder_sync

// File: doc/priority_encoder_sync.md
Name: priority_encoder_sync

Overview:
- Registered N-input priority encoder; default 4-to-2.
- Reports the index of the highest-numbered asserted request bit, plus a valid flag and a one-hot grant vector.
- Used wherever several request lines must be reduced to one binary index, such as interrupt or arbitration front-ends.
- Outputs are registered on the clock edge so downstream logic receives glitch-free values.

Parameters:
- WIDTH, 4, number of request inputs; must be ≥ 2.
- IDX_W, $clog2(WIDTH), width of the encoded index output; derived, not overridden.

Ports:
- clk  input  1  system clock; all registers update on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  capture enable; outputs update only when high.
- d  input  WIDTH  request vector; bit i set means request i is active.
- mask  input  WIDTH  per-bit enable; a request counts only where the mask bit is 1. Tie to all-ones for plain encoding.
- out  output  IDX_W  registered index of the highest-priority active request.
- valid  output  1  registered; 1 when at least one masked request was active at capture.
- onehot  output  WIDTH  registered one-hot form of out; all-zero when valid=0.

Behaviour:
- Reset: rst_n low clears out=0, valid=0 and onehot=0 immediately, independent of clk. Outputs stay cleared while rst_n is low.
- Reset deasserts asynchronously; the first capture occurs on the first rising edge after rst_n is high.
- Effective request: r = d & mask, computed combinationally.
- Priority rule: the highest set bit of r wins; bit WIDTH-1 has top priority and bit 0 the lowest.
- Capture: on a rising clk edge with en=1:
  - out <= index of the highest set bit of r.
  - valid <= |r.
  - onehot <= (1 << out_next) when |r, else 0.
- Hold: on a rising edge with en=0, all outputs keep their previous values.
- Latency: exactly 1 cycle from d/mask/en sampled to outputs visible. No combinational path from inputs to outputs.
- No-request case: r=0 gives out=0 and valid=0. out=0 is then ambiguous, so consumers must qualify out with valid.
- Multiple requests: lower bits are ignored entirely. Example for WIDTH=4: d=4'b1111 gives out=3; d=4'b0110 gives out=2.
- Full WIDTH=4 truth table (mask=all-ones, en=1):
  - 0000 → out 0, valid 0.
  - 0001 → out 0, valid 1.
  - 001x → out 1.
  - 01xx → out 2.
  - 1xxx → out 3.
- Non-power-of-two WIDTH (e.g. 5): IDX_W=3. out never exceeds WIDTH-1.
- Inputs are sampled only at clock edges; glitches on d between edges have no effect.
- Reset asserted mid-operation overrides en and any pending capture.

Decomposition:
- Shared package prio_pkg holds:
  - Function clog2_min1(n), returning max(1, $clog2(n)), used for IDX_W.
  - Default-width constant PRIO_WIDTH_DEF = 4.
- One sub-module, priority_encoder_core: purely combinational.
  - Inputs: r[WIDTH-1:0].
  - Outputs: idx[IDX_W-1:0], any, oh[WIDTH-1:0].
  - Implemented as a loop scanning bit 0 upward so the last (highest) set bit wins.
- The top level adds the mask AND, the en gating and the async-reset output registers.

Test Plan:
- Reset: hold rst_n=0 with d=4'b1000 and en=1 for 3 cycles → out=0, valid=0, onehot=0. Release rst_n; next edge → out=3, valid=1, onehot=4'b1000.
- Exhaustive sweep, WIDTH=4, mask=4'hF, en=1: step d from 0 to 15, one value per cycle → each result one cycle later.
  - d=0 → valid=0, out=0.
  - d=1 → out=0.
  - d=2..3 → out=1.
  - d=4..7 → out=2.
  - d=8..15 → out=3.
  - valid=1 for all non-zero d.
- Mask: d=4'b1010, mask=4'b0111 → out=1, onehot=4'b0010. mask=4'b0000 → valid=0.
- Enable hold: capture d=4'b0100 (out=2), then drop en and drive d=4'b1000 for 4 cycles → out stays 2. Raise en → out=3 on the next edge.
- Async reset mid-run: while out=3 and valid=1, pulse rst_n low between clock edges → outputs clear immediately, before the next edge.
- WIDTH=5: d=5'b10000 → out=3'd4. d=5'b00011 → out=3'd1. out never exceeds 4.
